cic_comp_fir: RTL and testbench
===============================

CIC_COMP_FIR -- requirements
Module: cic_comp_fir

Interface
REQ-001 Parameter BITS, default 32: width of stream_in and stream_out, signed two's complement.
REQ-002 Parameters C0, C1, C2, C3, defaults -1, 2, -6, 26: signed 8-bit coefficients. The taps are symmetric, h = [C0 C1 C2 C3 C2 C1 C0], with DC gain 16.
REQ-003 Parameter SHIFT, default 4: arithmetic right shift applied to the accumulator before output.
REQ-004 clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 rst, input, 1: reset, asynchronous and active-high.
REQ-006 stream_in, input, BITS: sample from the upstream CIC decimator's stream_out.
REQ-007 valid, input, 1: one-cycle strobe from the upstream CIC ready; stream_in is valid while it is high.
REQ-008 stream_out, output, BITS: compensated sample, registered, held between updates.
REQ-009 ready, output, 1: one-cycle strobe marking a new stream_out.
REQ-010 busy, output, 1: high whenever the state is not IDLE.
REQ-011 overrun, output, 1: sticky flag, set when a sample is dropped.

Function
REQ-012 The block SHALL implement a 7-tap symmetric FIR with a serial pre-add/MAC, producing one output per accepted sample.
REQ-013 States SHALL be IDLE, MAC and OUT. In MAC, a 2-bit tap counter k runs 0 to 3.
REQ-014 IDLE with valid=1 (edge E0):
- shift stream_in into the 7-entry delay line x[0..6] (x[0] newest);
- clear acc;
- set k=0;
- go to MAC.
REQ-015 MAC, edges E1 to E4:
- k=0..2: acc += Ck*(x[k]+x[6-k]);
- k=3: acc += C3*x[3], then go to OUT.
REQ-016 OUT, edge E5:
- stream_out <= sat(acc >>> SHIFT);
- ready <= 1 for exactly one cycle;
- go to IDLE.
REQ-017 Latency SHALL be 5 clock edges from the accepting edge to ready high. The minimum sample spacing is 6 cycles.
REQ-018 The accumulator SHALL be BITS+10 bits signed, and the pre-add SHALL be BITS+1 bits signed. No intermediate overflow is permitted.
REQ-019 sat() SHALL clamp to the range [-2^(BITS-1), 2^(BITS-1)-1].
REQ-020 valid=1 while busy=1 SHALL drop that sample and set overrun. The delay line, acc and state are unaffected, and overrun stays 1 until reset.
REQ-021 valid=1 in the same cycle that OUT returns to IDLE SHALL be dropped as in REQ-020, because acceptance occurs only in IDLE.
REQ-022 stream_in SHALL be ignored whenever valid=0.
REQ-023 ready SHALL never be high for two consecutive cycles.

Reset
REQ-024 rst=1 SHALL immediately force the following, regardless of state, including mid-MAC:
- state IDLE, k=0, acc=0;
- delay line all 0;
- stream_out=0, ready=0, busy=0, overrun=0.
REQ-025 The first sample after reset release SHALL be accepted on the first valid edge, with no extra wait cycle.

Configuration
REQ-026 Macro CIC_COMP_ROUND_EN defined: the output SHALL be sat((acc + 2^(SHIFT-1)) >>> SHIFT), i.e. round-half-up.
REQ-027 Macro CIC_COMP_ROUND_EN undefined: the output SHALL be sat(acc >>> SHIFT), i.e. truncation toward minus infinity. The rounding adder SHALL NOT be present.

Verification
REQ-028 Impulse, default parameters, macro off: input 16 then six 0s, one every 8 cycles. Required outputs are -1, 2, -6, 26, -6, 2, -1, each with a single ready pulse 5 edges after its valid.
REQ-029 Rounding: impulse of 1 then zeros.
- Macro off: outputs -1, 0, -1, 1, -1, 0, -1.
- Macro on: outputs 0, 0, 0, 2, 0, 0, 0.
REQ-030 DC: constant 100, spaced 8 cycles. From the 7th output onward, stream_out SHALL be 100.
REQ-031 Saturation, BITS=8: inputs 0, 0, -128, 127, -128, 0, 0 (acc=4838). The 7th output SHALL be 127. With inputs 0, 0, 127, -128, 127, 0, 0, the 7th output SHALL be -128.
REQ-032 Overrun: valid high two consecutive cycles with 5 then 6. Required response:
- only 5 is processed;
- exactly one ready pulse;
- overrun=1 from the second cycle onward.
REQ-033 Reset mid-MAC: pulse rst at edge E2 of a sample. Required response:
- ready stays 0;
- all outputs 0 at once;
- the next impulse input 16 yields -1 as its first output.

Source files
------------

// File: rtl/cic_comp_fir_if.sv
// Sample stream between the CIC decimator and its compensation FIR.
// valid/ready are one-cycle strobes: stream_in counts only while valid is high,
// stream_out is new exactly in the cycle ready is high and holds otherwise.
interface cic_comp_fir_if #(
    parameter int BITS = 32
);
    logic signed [BITS-1:0] stream_in;
    logic                   valid;
    logic signed [BITS-1:0] stream_out;
    logic                   ready;
    logic                   busy;
    logic                   overrun;

    modport master (
        output stream_in, valid,
        input  stream_out, ready, busy, overrun
    );

    modport slave (
        input  stream_in, valid,
        output stream_out, ready, busy, overrun
    );
endinterface

// File: rtl/cic_comp_fir.sv
// CIC compensation FIR: 7-tap symmetric, one serial pre-add/MAC per sample.
// Define CIC_COMP_ROUND_EN for round-half-up output; otherwise the output truncates.
module cic_comp_fir #(
    parameter int               BITS  = 32,
    parameter logic signed [7:0] C0   = -8'sd1,
    parameter logic signed [7:0] C1   = 8'sd2,
    parameter logic signed [7:0] C2   = -8'sd6,
    parameter logic signed [7:0] C3   = 8'sd26,
    parameter int               SHIFT = 4
) (
    input  logic               clk,
    input  logic               rst,
    cic_comp_fir_if.slave      bus,
    output logic [1:0]         state_dbg
);
    localparam int ACC_W = BITS + 10;
    localparam int PRE_W = BITS + 1;
    localparam logic signed [ACC_W-1:0] MAX_V = {{11{1'b0}}, {(BITS-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{11{1'b1}}, {(BITS-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [1:0]              k;
    logic signed [BITS-1:0]  x [7];
    logic signed [ACC_W-1:0] acc;
    logic                    accept;
    logic                    drop;
    logic signed [7:0]       coef;
    logic signed [PRE_W-1:0] pre_sum;
    logic signed [ACC_W-1:0] coef_ext;
    logic signed [ACC_W-1:0] pre_ext;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] scaled;
    logic signed [BITS-1:0]  sat_val;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.valid) begin
                    accept     = 1'b1;
                    state_next = MAC;
                end
            end
            MAC:     if (k == 2'd3) state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Anything offered outside IDLE is lost, including the OUT->IDLE cycle.
        drop = bus.valid && (state != IDLE);
    end

    // Symmetric taps share one multiply: tap k pairs x[k] with x[6-k]; the centre tap stands alone.
    always_comb begin
        coef    = C3;
        pre_sum = PRE_W'(x[3]);
        case (k)
            2'd0: begin coef = C0; pre_sum = PRE_W'(x[0]) + PRE_W'(x[6]); end
            2'd1: begin coef = C1; pre_sum = PRE_W'(x[1]) + PRE_W'(x[5]); end
            2'd2: begin coef = C2; pre_sum = PRE_W'(x[2]) + PRE_W'(x[4]); end
            2'd3: begin coef = C3; pre_sum = PRE_W'(x[3]); end
        endcase
        coef_ext = ACC_W'(coef);
        pre_ext  = ACC_W'(pre_sum);
        prod     = coef_ext * pre_ext;
    end

`ifdef CIC_COMP_ROUND_EN
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) <<< (SHIFT - 1);
    assign scaled = (acc + RND) >>> SHIFT;
`else
    assign scaled = acc >>> SHIFT;
`endif

    always_comb begin
        if (scaled > MAX_V)      sat_val = MAX_V[BITS-1:0];
        else if (scaled < MIN_V) sat_val = MIN_V[BITS-1:0];
        else                     sat_val = scaled[BITS-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k              <= '0;
            acc            <= '0;
            bus.stream_out <= '0;
            bus.ready      <= 1'b0;
            bus.overrun    <= 1'b0;
            for (int i = 0; i < 7; i++) x[i] <= '0;
        end else begin
            bus.ready <= 1'b0;
            if (drop) bus.overrun <= 1'b1;
            if (accept) begin
                x[0] <= bus.stream_in;
                for (int i = 1; i < 7; i++) x[i] <= x[i-1];
                acc <= '0;
                k   <= '0;
            end
            if (state == MAC) begin
                acc <= acc + prod;
                k   <= k + 2'd1;
            end
            if (state == OUT) begin
                bus.stream_out <= sat_val;
                bus.ready      <= 1'b1;
            end
        end
    end

    assign bus.busy  = (state != IDLE);
    assign state_dbg = state;
endmodule

// File: tb/tb_cic_comp_fir.sv
// Bench for cic_comp_fir: a 32-bit and an 8-bit instance checked every cycle
// against a convolution model of the filter plus literal expected sequences.
module tb_cic_comp_fir;
    localparam int SHIFT_M = 4;
    localparam int H [7] = '{-1, 2, -6, 26, -6, 2, -1};

    typedef struct {
        longint t;
        longint v;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [1:0] state_dbg32;
    logic [1:0] state_dbg8;

    cic_comp_fir_if #(.BITS(32)) if32 ();
    cic_comp_fir_if #(.BITS(8))  if8 ();

    cic_comp_fir #(.BITS(32)) dut32 (.clk(clk), .rst(rst), .bus(if32), .state_dbg(state_dbg32));
    cic_comp_fir #(.BITS(8))  dut8  (.clk(clk), .rst(rst), .bus(if8),  .state_dbg(state_dbg8));

    int     vectors;
    int     miscompares;
    longint cyc;
    longint hist [2][7];
    longint free_at [2];
    bit     ov_m [2];
    longint hold [2];
    exp_t   exp_q0 [$];
    exp_t   exp_q1 [$];
    longint seen0 [$];
    longint seen1 [$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint model_out(input int d, input int bits);
        longint acc;
        longint lim;
        acc = 0;
        for (int i = 0; i < 7; i++) acc += longint'(H[i]) * hist[d][i];
`ifdef CIC_COMP_ROUND_EN
        acc += (64'sd1 <<< (SHIFT_M - 1));
`endif
        acc = acc >>> SHIFT_M;
        lim = 64'sd1 <<< (bits - 1);
        if (acc > lim - 1) acc = lim - 1;
        if (acc < -lim)    acc = -lim;
        return acc;
    endfunction

    task automatic step(input int d, input logic vld, input longint din, input int bits);
        exp_t e;
        if (rst) begin
            for (int i = 0; i < 7; i++) hist[d][i] = 0;
            free_at[d] = 0;
            ov_m[d]    = 1'b0;
            if (d == 0) exp_q0.delete(); else exp_q1.delete();
            return;
        end
        if (vld !== 1'b1) return;
        if (cyc < free_at[d]) begin
            ov_m[d] = 1'b1;
        end else begin
            for (int i = 6; i > 0; i--) hist[d][i] = hist[d][i-1];
            hist[d][0] = din;
            free_at[d] = cyc + 6;
            e.t = cyc + 5;
            e.v = model_out(d, bits);
            if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        end
    endtask

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
            step(0, if32.valid, longint'(if32.stream_in), 32);
            step(1, if8.valid,  longint'(if8.stream_in),  8);
        end
    end

    // ---------------- scoreboard / compare ----------------
    task automatic check_dut(input int d, input longint out, input logic rdy,
                             input logic bsy, input logic ovr);
        exp_t  e;
        bit    hit;
        string p;
        p   = (d == 0) ? "b32" : "b8";
        hit = 1'b0;
        if (rst) begin
            hold[d] = 0;
            chk({p, "_rst_stream_out"}, out, 0);
            chk({p, "_rst_ready"}, longint'(rdy), 0);
            chk({p, "_rst_busy"}, longint'(bsy), 0);
            chk({p, "_rst_overrun"}, longint'(ovr), 0);
            return;
        end
        if (d == 0) begin
            if (exp_q0.size() > 0 && exp_q0[0].t == cyc) begin e = exp_q0.pop_front(); hit = 1'b1; end
        end else begin
            if (exp_q1.size() > 0 && exp_q1[0].t == cyc) begin e = exp_q1.pop_front(); hit = 1'b1; end
        end
        if (hit) hold[d] = e.v;
        chk({p, "_ready"}, longint'(rdy), hit ? 64'sd1 : 64'sd0);
        chk({p, "_stream_out"}, out, hold[d]);
        chk({p, "_busy"}, longint'(bsy), (cyc <= free_at[d] - 2) ? 64'sd1 : 64'sd0);
        chk({p, "_overrun"}, longint'(ovr), ov_m[d] ? 64'sd1 : 64'sd0);
        if (rdy === 1'b1) begin
            if (d == 0) seen0.push_back(out); else seen1.push_back(out);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check_dut(0, longint'(if32.stream_out), if32.ready, if32.busy, if32.overrun);
            check_dut(1, longint'(if8.stream_out),  if8.ready,  if8.busy,  if8.overrun);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int d, input longint val, input int gap);
        @(negedge clk);
        if (d == 0) begin if32.valid = 1'b1; if32.stream_in = val[31:0]; end
        else        begin if8.valid  = 1'b1; if8.stream_in  = val[7:0];  end
        @(negedge clk);
        if (d == 0) begin if32.valid = 1'b0; if32.stream_in = $urandom; end
        else        begin if8.valid  = 1'b0; if8.stream_in  = 8'($urandom); end
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        longint imp_exp [7];
        longint rnd_exp [7];
        longint sat_a [7];
        longint sat_b [7];
        int     n;

        imp_exp = '{-1, 2, -6, 26, -6, 2, -1};
`ifdef CIC_COMP_ROUND_EN
        rnd_exp = '{0, 0, 0, 2, 0, 0, 0};
`else
        rnd_exp = '{-1, 0, -1, 1, -1, 0, -1};
`endif
        sat_a = '{0, 0, -128, 127, -128, 0, 0};
        sat_b = '{0, 0, 127, -128, 127, 0, 0};

        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        if32.valid = 1'b0; if32.stream_in = '0;
        if8.valid  = 1'b0; if8.stream_in  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_state32", longint'(state_dbg32), 0);
        chk("reset_state8", longint'(state_dbg8), 0);
        chk("reset_out32", longint'(if32.stream_out), 0);

        // Impulse of 16: outputs are the taps themselves.
        seen0.delete();
        send(0, 16, 8);
        for (int i = 0; i < 6; i++) send(0, 0, 8);
        chk("impulse_count", seen0.size(), 7);
        for (int i = 0; i < 7; i++) if (i < seen0.size()) chk("impulse_tap", seen0[i], imp_exp[i]);

        // Impulse of 1 exposes the output rounding mode.
        seen0.delete();
        send(0, 1, 8);
        for (int i = 0; i < 6; i++) send(0, 0, 8);
        chk("round_count", seen0.size(), 7);
        for (int i = 0; i < 7; i++) if (i < seen0.size()) chk("round_tap", seen0[i], rnd_exp[i]);

        // DC gain 16 with a shift of 4 gives unity once the line is full.
        seen0.delete();
        for (int i = 0; i < 10; i++) send(0, 100, 8);
        chk("dc_count", seen0.size(), 10);
        for (int i = 6; i < 10; i++) if (i < seen0.size()) chk("dc_value", seen0[i], 100);

        // Saturation on the 8-bit instance, both rails.
        seen1.delete();
        for (int i = 0; i < 7; i++) send(1, sat_a[i], 8);
        for (int i = 0; i < 7; i++) send(1, sat_b[i], 8);
        chk("sat_count", seen1.size(), 14);
        if (seen1.size() >= 14) begin
            chk("sat_high", seen1[6], 127);
            chk("sat_low", seen1[13], -128);
        end

        // Reset in the middle of the MAC sequence.
        n = seen0.size();
        send(0, 500, 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("rst_async_out", longint'(if32.stream_out), 0);
        chk("rst_async_busy", longint'(if32.busy), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("rst_no_ready", seen0.size(), n);
        send(0, 16, 8);
        chk("rst_next_count", seen0.size(), n + 1);
        if (seen0.size() > n) chk("rst_next_first", seen0[n], -1);

        // Back-to-back valid: the second sample is dropped and flagged.
        do_reset();
        n = seen0.size();
        @(negedge clk);
        if32.valid = 1'b1; if32.stream_in = 32'sd5;
        @(negedge clk);
        if32.stream_in = 32'sd6;
        @(negedge clk);
        if32.valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("ovr_ready_count", seen0.size(), n + 1);
`ifdef CIC_COMP_ROUND_EN
        if (seen0.size() > n) chk("ovr_value", seen0[n], 0);
`else
        if (seen0.size() > n) chk("ovr_value", seen0[n], -1);
`endif
        chk("ovr_sticky", longint'(if32.overrun), 1);

        // Random traffic with spacing that sometimes violates the minimum.
        do_reset();
        for (int i = 0; i < 80; i++) begin
            send(0, longint'($signed($urandom)), $urandom_range(1, 9));
            if ($urandom_range(0, 3) == 0) send(1, longint'($signed(8'($urandom))), $urandom_range(2, 8));
        end
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
